// File: rtl/memoria_dados_pkg.sv
// memoria_dados_pkg: access-size encodings, default depth and alignment helper
package memoria_dados_pkg;

   typedef enum logic [1:0] {
      TAM_BYTE = 2'b00,
      TAM_HALF = 2'b01,
      TAM_WORD = 2'b10,
      TAM_RSV  = 2'b11
   } tamanho_e;

   localparam int PROFUNDIDADE_PADRAO = 256;

   function automatic logic desalinhado(input logic [1:0] tam, input logic [1:0] off);
      return (tam == TAM_HALF && off[0]) || (tam == TAM_WORD && off != 2'b00) || tam == TAM_RSV;
   endfunction

endpackage

// File: rtl/memoria_dados_extensor_carga.sv
// extensor_carga: picks the addressed byte/half of a word, right-justifies it and extends it
module extensor_carga
   import memoria_dados_pkg::*;
(
   input  logic [31:0] palavra_i,
   input  logic [1:0]  desloc_i,
   input  logic [1:0]  tamanho_i,
   input  logic        sinal_i,
   output logic [31:0] valor_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = palavra_i[{desloc_i, 3'b000} +: 8];
      half_sel = desloc_i[1] ? palavra_i[31:16] : palavra_i[15:0];
      valor_o  = tamanho_i == TAM_BYTE ? {{24{sinal_i & byte_sel[7]}}, byte_sel} :
                 tamanho_i == TAM_HALF ? {{16{sinal_i & half_sel[15]}}, half_sel} :
                 palavra_i;
   end

endmodule

// File: rtl/memoria_dados.sv
// memoria_dados: byte-addressable little-endian data memory with 1-cycle registered loads
module memoria_dados
   import memoria_dados_pkg::*;
#(
   parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [1:0]  tamanho,
   input  logic        sinal,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        erro_alinhamento
);

   localparam int AW = $clog2(PROFUNDIDADE);

   logic [31:0]   mem_q [PROFUNDIDADE];
   logic [31:0]   read_data_q, read_data_d;
   logic          read_valid_q, read_valid_d;
   logic          erro_q, erro_d;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          desal, escreve, le;
   logic [3:0]    be;
   logic [31:0]   wdata, carga;
   logic          unused_bits;

   assign unused_bits = ^address[31:AW+2];

   extensor_carga u_ext (
      .palavra_i (mem_q[idx]),
      .desloc_i  (off),
      .tamanho_i (tamanho),
      .sinal_i   (sinal),
      .valor_o   (carga)
   );

   // a simultaneous read+write is treated as a store only
   always_comb begin
      idx          = address[AW+1:2];
      off          = address[1:0];
      desal        = desalinhado(tamanho, off);
      escreve      = MemWrite && !desal;
      le           = MemRead && !MemWrite && !desal;
      be           = tamanho == TAM_BYTE ? 4'b0001 << off :
                     tamanho == TAM_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata        = tamanho == TAM_BYTE ? {4{write_data[7:0]}} :
                     tamanho == TAM_HALF ? {2{write_data[15:0]}} : write_data;
      read_data_d  = le ? carga : read_data_q;
      read_valid_d = le;
      erro_d       = (MemRead || MemWrite) && desal;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         erro_q       <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (escreve && be[k]) mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         erro_q       <= erro_d;
      end
   end

   assign read_data        = read_data_q;
   assign read_valid       = read_valid_q;
   assign erro_alinhamento = erro_q;

endmodule
